lcd_timing_driver: RTL

//  RGB-LCD timing generator and pixel sink; the opposite end of the pixel-request interface.

---
 rtl/lcd_timing_driver.sv | 99 +++++++++
 1 files changed

// File: rtl/lcd_timing_driver.sv
// RGB-LCD timing generator: free-running H/V counters, one-cycle-ahead pixel requests,
// and a single aligned output register stage for the panel pins.
module lcd_timing_driver #(
    parameter int unsigned H_SYNC   = 128,
    parameter int unsigned H_BACK   = 88,
    parameter int unsigned H_DISP   = 800,
    parameter int unsigned H_FRONT  = 40,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 33,
    parameter int unsigned V_DISP   = 480,
    parameter int unsigned V_FRONT  = 10,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic        lcd_pclk,
    input  logic        rst_n,
    input  logic [23:0] pixel_data,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic [10:0] h_disp,
    output logic [10:0] v_disp,
    output logic        lcd_hs,
    output logic        lcd_vs,
    output logic        lcd_de,
    output logic [23:0] lcd_rgb,
    output logic        lcd_bl,
    output logic        frame_start
);

    localparam int unsigned CW      = 11;
    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;

    localparam logic [CW-1:0] HT_M1   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] VT_M1   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] HS_END  = CW'(H_SYNC);
    localparam logic [CW-1:0] VS_END  = CW'(V_SYNC);
    localparam logic [CW-1:0] HSB     = CW'(H_SYNC + H_BACK);
    localparam logic [CW-1:0] HDE     = CW'(H_SYNC + H_BACK + H_DISP);
    localparam logic [CW-1:0] VSB     = CW'(V_SYNC + V_BACK);
    localparam logic [CW-1:0] VDE     = CW'(V_SYNC + V_BACK + V_DISP);
    // Requests lead the display window by one cycle to cover the source's register stage.
    localparam logic [CW-1:0] HREQ_LO = CW'(H_SYNC + H_BACK - 1);
    localparam logic [CW-1:0] HREQ_HI = CW'(H_SYNC + H_BACK + H_DISP - 1);

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          active_line;
    logic          req_win;
    logic          de_i;
    logic          hs_i;
    logic          vs_i;

    // Horizontal counter wraps every line; vertical advances on the horizontal wrap.
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == HT_M1) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == VT_M1) ? '0 : v_cnt + CW'(1);
        end else begin
            h_cnt <= h_cnt + CW'(1);
        end
    end

    // Phase decode and pixel request coordinates.
    always_comb begin
        active_line = (v_cnt >= VSB) && (v_cnt < VDE);
        req_win     = active_line && (h_cnt >= HREQ_LO) && (h_cnt < HREQ_HI);
        de_i        = active_line && (h_cnt >= HSB) && (h_cnt < HDE);
        hs_i        = (h_cnt < HS_END);
        vs_i        = (v_cnt < VS_END);
        pixel_xpos  = req_win ? (h_cnt - HREQ_LO) : '0;
        pixel_ypos  = req_win ? (v_cnt - VSB) : '0;
    end

    // Single register stage keeps all panel pins mutually aligned.
    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            lcd_hs      <= ~SYNC_POL;
            lcd_vs      <= ~SYNC_POL;
            lcd_de      <= 1'b0;
            lcd_rgb     <= '0;
            lcd_bl      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            lcd_hs      <= hs_i ? SYNC_POL : ~SYNC_POL;
            lcd_vs      <= vs_i ? SYNC_POL : ~SYNC_POL;
            lcd_de      <= de_i;
            lcd_rgb     <= de_i ? pixel_data : '0;
            lcd_bl      <= 1'b1;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
        end
    end

    assign h_disp = CW'(H_DISP);
    assign v_disp = CW'(V_DISP);

endmodule
